load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Stores have no unsigned variants.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    logic base;
    base = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (is_store) return base;
    return base || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication and load extraction
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    case (funct3[1:0])
      2'b00: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be          = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
      end
      default: begin
        be          = 4'b1111;
        wdata_lanes = wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  assign shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    rdata_ext = rword;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
      F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
      default: rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with bus timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] rdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata
);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [31:0] rdata_q;
  logic [31:0] cnt;

  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_ext;

  logic accept;
  logic bad_op;
  logic bad_align;
  logic timeout_hit;

  lsu_align u_align (
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rword       (resp_rdata),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  assign accept      = (state == ST_IDLE) && start && (mem_read || mem_write);
  assign bad_op      = (mem_read && mem_write) || !funct3_legal(funct3, mem_write);
  assign bad_align   = misaligned(funct3, addr[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt >= TIMEOUT - 1);

  // A bus handshake or response in the final counted cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      rdata_q    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            we_q     <= mem_write;
            rdata_q  <= '0;
            cnt      <= '0;
            if (bad_op) begin
              state      <= ST_DONE;
              err_q      <= 1'b1;
              err_code_q <= ERR_ILLEGAL;
            end else if (bad_align) begin
              state      <= ST_DONE;
              err_q      <= 1'b1;
              err_code_q <= ERR_MISALIGN;
            end else begin
              state      <= ST_REQ;
              err_q      <= 1'b0;
              err_code_q <= ERR_NONE;
            end
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            state <= ST_WAIT;
            cnt   <= cnt + 32'd1;
          end else if (timeout_hit) begin
            state      <= ST_DONE;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            state   <= ST_DONE;
            rdata_q <= we_q ? 32'd0 : rdata_ext;
          end else if (timeout_hit) begin
            state      <= ST_DONE;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_REQ) || (state == ST_WAIT);
  assign done      = (state == ST_DONE);
  assign err       = done && err_q;
  assign err_code  = done ? err_code_q : ERR_NONE;
  assign rdata     = done ? rdata_q : 32'd0;

  assign req_valid = (state == ST_REQ);
  assign req_we    = req_valid && we_q;
  assign req_addr  = req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign req_be    = req_valid ? be : 4'd0;
  assign req_wdata = req_valid ? wdata_lanes : 32'd0;

endmodule
